// File: rtl/cpu_exec_mc.sv
// Multi-cycle execute stage: single-cycle ALU/branch path plus an iterative MUL/DIV
// engine, with a valid/ready handshake on input and a registered output slot.
package pck_control;
   typedef enum logic [3:0] {
      ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
      ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
   } alu_op_e;
   typedef enum logic [1:0] {OPA_RS1, OPA_PC, OPA_ZERO} opa_e;
   typedef enum logic [1:0] {OPB_RS2, OPB_IMM, OPB_FOUR} opb_e;
   typedef enum logic [3:0] {
      BR_NONE, BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JAL, BR_JALR
   } br_e;
   // Signedness of MUL/DIV operands comes from the separate opa/opb_signed inputs.
   typedef enum logic [2:0] {MD_NONE, MD_MUL, MD_MULH, MD_DIV, MD_REM} md_op_e;
   typedef enum logic {WB_ALU, WB_MD} wb_e;
endpackage

module cpu_exec_mc
   import pck_control::*;
#(
   parameter int p_xlen       = 32,
   parameter int p_ext_rvm    = 1,
   parameter int p_md_bits    = 1,
   parameter int p_branch_buf = 0
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_flush,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic [p_xlen-1:0] i_rs1,
   input  logic [p_xlen-1:0] i_rs2,
   input  logic [p_xlen-1:0] i_imm,
   input  logic [p_xlen-1:0] i_pc,
   input  alu_op_e           i_sel_alu_op,
   input  opa_e              i_sel_opa,
   input  opb_e              i_sel_opb,
   input  br_e               i_sel_br,
   input  md_op_e            i_sel_md_op,
   input  wb_e               i_sel_wb,
   input  logic              i_opa_signed,
   input  logic              i_opb_signed,
   output logic              o_valid,
   input  logic              i_ready,
   output logic [p_xlen-1:0] o_result,
   output logic              o_branch_taken,
   output logic [p_xlen-1:0] o_branch_target
);
   localparam int lp_sh = $clog2(p_xlen);
   localparam int lp_mw = p_xlen + p_md_bits;
   localparam int lp_cw = $clog2(p_xlen + 2);
   localparam logic [lp_cw-1:0] lp_mul_cnt = lp_cw'(p_xlen / p_md_bits);
   localparam logic [lp_cw-1:0] lp_div_cnt = lp_cw'(p_xlen + 1);

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_BRW} state_e;
   state_e r_state, w_state_next;

   logic w_slot_free, w_accept, w_is_md, w_use_engine, w_is_cond;
   logic w_load, w_load_taken, w_latch_md, w_latch_br, w_eng_step;
   logic [p_xlen-1:0] w_load_res, w_load_target;

   assign w_slot_free  = !o_valid || i_ready;
   assign o_ready      = (r_state == S_IDLE) && w_slot_free && !i_rst;
   assign w_accept     = i_valid && o_ready && !i_flush;
   assign w_is_md      = (i_sel_md_op != MD_NONE);
   assign w_use_engine = w_is_md && (p_ext_rvm != 0);
   assign w_is_cond    = i_sel_br inside {BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU};

   // ---------------- single-cycle ALU and branch unit ----------------
   logic [p_xlen-1:0] w_opa, w_opb, w_alu, w_single_res, w_target_in;
   logic [lp_sh-1:0]  w_shamt;
   logic              w_cond, w_taken_in;

   always_comb begin
      w_opa = i_rs1;
      case (i_sel_opa)
         OPA_PC:   w_opa = i_pc;
         OPA_ZERO: w_opa = '0;
         default:  w_opa = i_rs1;
      endcase
      w_opb = i_rs2;
      case (i_sel_opb)
         OPB_IMM:  w_opb = i_imm;
         OPB_FOUR: w_opb = p_xlen'(4);
         default:  w_opb = i_rs2;
      endcase
      w_shamt = w_opb[lp_sh-1:0];
      case (i_sel_alu_op)
         ALU_SUB:   w_alu = w_opa - w_opb;
         ALU_SLL:   w_alu = w_opa << w_shamt;
         ALU_SLT:   w_alu = p_xlen'($signed(w_opa) < $signed(w_opb));
         ALU_SLTU:  w_alu = p_xlen'(w_opa < w_opb);
         ALU_XOR:   w_alu = w_opa ^ w_opb;
         ALU_SRL:   w_alu = w_opa >> w_shamt;
         ALU_SRA:   w_alu = $signed(w_opa) >>> w_shamt;
         ALU_OR:    w_alu = w_opa | w_opb;
         ALU_AND:   w_alu = w_opa & w_opb;
         ALU_PASSB: w_alu = w_opb;
         default:   w_alu = w_opa + w_opb;
      endcase
      case (i_sel_br)
         BR_EQ:   w_cond = (i_rs1 == i_rs2);
         BR_NE:   w_cond = (i_rs1 != i_rs2);
         BR_LT:   w_cond = ($signed(i_rs1) < $signed(i_rs2));
         BR_GE:   w_cond = ($signed(i_rs1) >= $signed(i_rs2));
         BR_LTU:  w_cond = (i_rs1 < i_rs2);
         BR_GEU:  w_cond = (i_rs1 >= i_rs2);
         default: w_cond = 1'b0;
      endcase
      w_taken_in  = w_cond || (i_sel_br == BR_JAL) || (i_sel_br == BR_JALR);
      w_target_in = (i_sel_br == BR_JALR) ? ((i_rs1 + i_imm) & ~p_xlen'(1)) : (i_pc + i_imm);
      // Without the engine an md op retires immediately with a zero result.
      w_single_res = (w_is_md || i_sel_wb == WB_MD) ? '0 : w_alu;
   end

   // ---------------- iterative MUL/DIV engine ----------------
   md_op_e            r_md_op;
   logic [p_xlen-1:0] r_hi, r_lo, r_opnd, r_dividend;
   logic              r_neg, r_a_neg, r_div_zero;
   logic [lp_cw-1:0]  r_cnt;

   logic [p_xlen-1:0]   w_a_mag, w_b_mag, w_hi_next, w_lo_next, w_md_res;
   logic                w_a_neg, w_b_neg, w_md_is_div, w_last, w_ge;
   logic [lp_mw-1:0]    w_mul_sum;
   logic [2*p_xlen-1:0] w_prod, w_prod_fix;
   logic [p_xlen:0]     w_rem_sh, w_diff;

   assign w_a_neg     = i_opa_signed && i_rs1[p_xlen-1];
   assign w_b_neg     = i_opb_signed && i_rs2[p_xlen-1];
   assign w_a_mag     = w_a_neg ? -i_rs1 : i_rs1;
   assign w_b_mag     = w_b_neg ? -i_rs2 : i_rs2;
   assign w_md_is_div = (r_md_op == MD_DIV) || (r_md_op == MD_REM);
   assign w_last      = (r_cnt == lp_cw'(1));

   // Multiply: shift-add on magnitudes, p_md_bits multiplier bits per step.
   assign w_mul_sum  = {{p_md_bits{1'b0}}, r_hi} + lp_mw'(r_opnd) * lp_mw'(r_lo[p_md_bits-1:0]);
   assign w_prod     = {w_mul_sum, r_lo[p_xlen-1:p_md_bits]};
   assign w_prod_fix = r_neg ? -w_prod : w_prod;
   // Divide: restoring, one quotient bit per step; quotient shifts into r_lo.
   assign w_rem_sh   = {r_hi, r_lo[p_xlen-1]};
   assign w_diff     = w_rem_sh - {1'b0, r_opnd};
   assign w_ge       = !w_diff[p_xlen];

   always_comb begin
      if (w_md_is_div) begin
         w_hi_next = w_ge ? w_diff[p_xlen-1:0] : w_rem_sh[p_xlen-1:0];
         w_lo_next = {r_lo[p_xlen-2:0], w_ge};
      end else begin
         w_hi_next = w_prod[2*p_xlen-1:p_xlen];
         w_lo_next = w_prod[p_xlen-1:0];
      end
      case (r_md_op)
         MD_MUL:  w_md_res = w_prod_fix[p_xlen-1:0];
         MD_MULH: w_md_res = w_prod_fix[2*p_xlen-1:p_xlen];
         MD_DIV:  w_md_res = r_div_zero ? '1 : (r_neg ? -r_lo : r_lo);
         MD_REM:  w_md_res = r_div_zero ? r_dividend : (r_a_neg ? -r_hi : r_hi);
         default: w_md_res = '0;
      endcase
   end

   // ---------------- control FSM ----------------
   logic              r_br_taken;
   logic [p_xlen-1:0] r_br_res, r_br_target;

   always_ff @(posedge i_clk) begin
      if (i_rst) r_state <= S_IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next  = r_state;
      w_load        = 1'b0;
      w_load_res    = w_single_res;
      w_load_taken  = w_taken_in;
      w_load_target = w_target_in;
      w_latch_md    = 1'b0;
      w_latch_br    = 1'b0;
      w_eng_step    = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (w_use_engine) begin
                  w_latch_md   = 1'b1;
                  w_state_next = S_BUSY;
               end else if (p_branch_buf != 0 && w_is_cond) begin
                  w_latch_br   = 1'b1;
                  w_state_next = S_BRW;
               end else begin
                  w_load = 1'b1;
               end
            end
         end
         S_BRW: begin
            w_load_res    = r_br_res;
            w_load_taken  = r_br_taken;
            w_load_target = r_br_target;
            if (w_slot_free) begin
               w_load       = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         S_BUSY: begin
            w_load_res    = w_md_res;
            w_load_taken  = 1'b0;
            w_load_target = '0;
            // The final step is held until the slot can take the result.
            if (!w_last) begin
               w_eng_step = 1'b1;
            end else if (w_slot_free) begin
               w_load       = 1'b1;
               w_state_next = S_IDLE;
            end
         end
         default: w_state_next = S_IDLE;
      endcase
      if (i_flush) begin
         w_state_next = S_IDLE;
         w_load       = 1'b0;
         w_latch_md   = 1'b0;
         w_latch_br   = 1'b0;
         w_eng_step   = 1'b0;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_md_op    <= MD_NONE;
         r_hi       <= '0;
         r_lo       <= '0;
         r_opnd     <= '0;
         r_dividend <= '0;
         r_neg      <= 1'b0;
         r_a_neg    <= 1'b0;
         r_div_zero <= 1'b0;
         r_cnt      <= '0;
      end else if (w_latch_md) begin
         r_md_op    <= i_sel_md_op;
         r_hi       <= '0;
         r_dividend <= i_rs1;
         r_neg      <= w_a_neg ^ w_b_neg;
         r_a_neg    <= w_a_neg;
         r_div_zero <= (i_rs2 == '0);
         if (i_sel_md_op == MD_DIV || i_sel_md_op == MD_REM) begin
            r_lo   <= w_a_mag;
            r_opnd <= w_b_mag;
            r_cnt  <= lp_div_cnt;
         end else begin
            r_lo   <= w_b_mag;
            r_opnd <= w_a_mag;
            r_cnt  <= lp_mul_cnt;
         end
      end else if (w_eng_step) begin
         r_hi  <= w_hi_next;
         r_lo  <= w_lo_next;
         r_cnt <= r_cnt - lp_cw'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_br_taken  <= 1'b0;
         r_br_res    <= '0;
         r_br_target <= '0;
      end else if (w_latch_br) begin
         r_br_taken  <= w_taken_in;
         r_br_res    <= w_single_res;
         r_br_target <= w_target_in;
      end
   end

   // ---------------- output slot ----------------
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_valid         <= 1'b0;
         o_result        <= '0;
         o_branch_taken  <= 1'b0;
         o_branch_target <= '0;
      end else if (i_flush) begin
         o_valid <= 1'b0;
      end else if (w_load) begin
         o_valid         <= 1'b1;
         o_result        <= w_load_res;
         o_branch_taken  <= w_load_taken;
         o_branch_target <= w_load_target;
      end else if (i_ready) begin
         o_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_cpu_exec_mc.sv
// Directed bench for cpu_exec_mc (xlen=32, RV32M, 1 multiplier bit per cycle).
module tb_cpu_exec_mc;
   import pck_control::*;

   logic        clk = 1'b0;
   logic        rst, flush, valid, ready_in;
   logic        o_ready, o_valid, o_taken;
   logic [31:0] rs1, rs2, imm, pc, o_result, o_target;
   alu_op_e     sel_alu;
   opa_e        sel_opa;
   opb_e        sel_opb;
   br_e         sel_br;
   md_op_e      sel_md;
   wb_e         sel_wb;
   logic        sa, sb;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   cpu_exec_mc #(.p_xlen(32), .p_ext_rvm(1), .p_md_bits(1), .p_branch_buf(0)) dut (
      .i_clk(clk), .i_rst(rst), .i_flush(flush), .i_valid(valid), .o_ready(o_ready),
      .i_rs1(rs1), .i_rs2(rs2), .i_imm(imm), .i_pc(pc),
      .i_sel_alu_op(sel_alu), .i_sel_opa(sel_opa), .i_sel_opb(sel_opb),
      .i_sel_br(sel_br), .i_sel_md_op(sel_md), .i_sel_wb(sel_wb),
      .i_opa_signed(sa), .i_opb_signed(sb),
      .o_valid(o_valid), .i_ready(ready_in), .o_result(o_result),
      .o_branch_taken(o_taken), .o_branch_target(o_target)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input alu_op_e alu, input opa_e opa, input opb_e opb, input br_e br,
                        input md_op_e md, input wb_e wb, input logic s_a, input logic s_b,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] im, input logic [31:0] p);
      sel_alu = alu; sel_opa = opa; sel_opb = opb; sel_br = br;
      sel_md = md; sel_wb = wb; sa = s_a; sb = s_b;
      rs1 = a; rs2 = b; imm = im; pc = p;
      valid = 1'b1;
   endtask

   task automatic run_op(input string tag, input alu_op_e alu, input opa_e opa, input opb_e opb,
                         input br_e br, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] im, input logic [31:0] p,
                         input logic [31:0] exp_res, input logic exp_taken,
                         input logic chk_tgt, input logic [31:0] exp_tgt);
      drive(alu, opa, opb, br, MD_NONE, WB_ALU, 1'b0, 1'b0, a, b, im, p);
      tick();
      valid = 1'b0;
      $display("op %s: valid=%0b result=%h taken=%0b target=%h", tag, o_valid, o_result, o_taken, o_target);
      chk({tag, "_valid"}, 64'(o_valid), 64'(1));
      chk({tag, "_res"}, 64'(o_result), 64'(exp_res));
      chk({tag, "_taken"}, 64'(o_taken), 64'(exp_taken));
      if (chk_tgt) chk({tag, "_target"}, 64'(o_target), 64'(exp_tgt));
   endtask

   task automatic run_md(input string tag, input md_op_e md, input logic s_a, input logic s_b,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat);
      int lat;
      drive(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, md, WB_MD, s_a, s_b, a, b, 32'h0, 32'h0);
      tick();
      valid = 1'b0;
      lat = 1;
      chk({tag, "_busy_ready"}, 64'(o_ready), 64'(0));
      while (!o_valid && lat < 100) begin
         tick();
         lat++;
      end
      $display("md %s: latency=%0d result=%h", tag, lat, o_result);
      chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
      chk({tag, "_res"}, 64'(o_result), 64'(exp_res));
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int rises;
      rst = 1'b1; flush = 1'b0; valid = 1'b0; ready_in = 1'b1;
      drive(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, MD_NONE, WB_ALU, 1'b0, 1'b0, 0, 0, 0, 0);
      valid = 1'b0;
      tick(); tick();
      $display("reset: valid=%0b ready=%0b result=%h", o_valid, o_ready, o_result);
      chk("rst_valid", 64'(o_valid), 64'(0));
      chk("rst_ready", 64'(o_ready), 64'(0));
      chk("rst_result", 64'(o_result), 64'(0));
      chk("rst_taken", 64'(o_taken), 64'(0));
      chk("rst_target", 64'(o_target), 64'(0));
      rst = 1'b0;
      #1;
      chk("post_rst_ready", 64'(o_ready), 64'(1));

      // back-to-back single-cycle ops
      run_op("add1", ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, 5, 7, 0, 0, 12, 1'b0, 1'b0, 0);
      chk("b2b_ready", 64'(o_ready), 64'(1));
      run_op("add2", ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, 10, 20, 0, 0, 30, 1'b0, 1'b0, 0);
      run_op("sub", ALU_SUB, OPA_RS1, OPB_RS2, BR_NONE, 0, 1, 0, 0, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
      run_op("sll", ALU_SLL, OPA_RS1, OPB_RS2, BR_NONE, 3, 33, 0, 0, 6, 1'b0, 1'b0, 0);
      run_op("sra", ALU_SRA, OPA_RS1, OPB_RS2, BR_NONE, 32'h8000_0000, 4, 0, 0, 32'hF800_0000, 1'b0, 1'b0, 0);
      run_op("srl", ALU_SRL, OPA_RS1, OPB_RS2, BR_NONE, 32'h8000_0000, 4, 0, 0, 32'h0800_0000, 1'b0, 1'b0, 0);
      run_op("slt", ALU_SLT, OPA_RS1, OPB_RS2, BR_NONE, 32'hFFFF_FFFF, 1, 0, 0, 1, 1'b0, 1'b0, 0);
      run_op("sltu", ALU_SLTU, OPA_RS1, OPB_RS2, BR_NONE, 32'hFFFF_FFFF, 1, 0, 0, 0, 1'b0, 1'b0, 0);
      run_op("addi", ALU_ADD, OPA_RS1, OPB_IMM, BR_NONE, 100, 0, 32'hFFFF_FFFE, 0, 98, 1'b0, 1'b0, 0);

      // branches and jumps
      run_op("beq", ALU_ADD, OPA_RS1, OPB_RS2, BR_EQ, 3, 3, 32'h20, 32'h100, 6, 1'b1, 1'b1, 32'h120);
      run_op("bne", ALU_ADD, OPA_RS1, OPB_RS2, BR_NE, 3, 3, 32'h20, 32'h100, 6, 1'b0, 1'b0, 0);
      run_op("blt", ALU_ADD, OPA_RS1, OPB_RS2, BR_LT, 32'hFFFF_FFFF, 1, 32'h8, 32'h40, 0, 1'b1, 1'b1, 32'h48);
      run_op("bltu", ALU_ADD, OPA_RS1, OPB_RS2, BR_LTU, 32'hFFFF_FFFF, 1, 32'h8, 32'h40, 0, 1'b0, 1'b0, 0);
      run_op("jalr", ALU_ADD, OPA_PC, OPB_FOUR, BR_JALR, 32'h201, 0, 0, 32'h100, 32'h104, 1'b1, 1'b1, 32'h200);
      run_op("jal", ALU_ADD, OPA_PC, OPB_FOUR, BR_JAL, 0, 0, 32'h10, 32'h300, 32'h304, 1'b1, 1'b1, 32'h310);

      // MUL: 33-cycle latency, DIV/REM: 34-cycle latency
      run_md("mulhu", MD_MULH, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
      run_md("mul_neg", MD_MUL, 1'b1, 1'b1, 32'hFFFF_FFFD, 5, 32'hFFFF_FFF1, 33);
      run_md("mulh_min", MD_MULH, 1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33);
      run_md("mulhsu", MD_MULH, 1'b1, 1'b0, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFF, 33);
      run_md("div_by0", MD_DIV, 1'b0, 1'b0, 7, 0, 32'hFFFF_FFFF, 34);
      run_md("rem_by0", MD_REM, 1'b0, 1'b0, 7, 0, 7, 34);
      run_md("div_ovf", MD_DIV, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 34);
      run_md("rem_ovf", MD_REM, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 34);
      run_md("div_sneg", MD_DIV, 1'b1, 1'b1, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD, 34);
      run_md("rem_sneg", MD_REM, 1'b1, 1'b1, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF, 34);
      run_md("rem_neg_by0", MD_REM, 1'b1, 1'b1, 32'hFFFF_FFF9, 0, 32'hFFFF_FFF9, 34);
      run_md("divu", MD_DIV, 1'b0, 1'b0, 100, 7, 14, 34);
      run_md("remu", MD_REM, 1'b0, 1'b0, 100, 7, 2, 34);
      tick();

      // back-pressure: slot holds, no new op accepted until release
      ready_in = 1'b0;
      drive(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, MD_NONE, WB_ALU, 1'b0, 1'b0, 1, 2, 0, 0);
      tick();
      drive(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, MD_NONE, WB_ALU, 1'b0, 1'b0, 4, 5, 0, 0);
      chk("stall_valid", 64'(o_valid), 64'(1));
      chk("stall_res0", 64'(o_result), 64'(3));
      for (int i = 0; i < 3; i++) begin
         tick();
         $display("stall cycle %0d: valid=%0b ready=%0b result=%h", i, o_valid, o_ready, o_result);
         chk($sformatf("stall_hold_res%0d", i), 64'(o_result), 64'(3));
         chk($sformatf("stall_hold_ready%0d", i), 64'(o_ready), 64'(0));
      end
      ready_in = 1'b1;
      tick();
      valid = 1'b0;
      chk("release_valid", 64'(o_valid), 64'(1));
      chk("release_res", 64'(o_result), 64'(9));
      tick();
      chk("drained_valid", 64'(o_valid), 64'(0));

      // flush of a full, stalled slot
      ready_in = 1'b0;
      drive(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, MD_NONE, WB_ALU, 1'b0, 1'b0, 8, 8, 0, 0);
      tick();
      valid = 1'b0;
      chk("flslot_valid", 64'(o_valid), 64'(1));
      flush = 1'b1;
      tick();
      flush = 1'b0;
      ready_in = 1'b1;
      $display("flush slot: valid=%0b", o_valid);
      chk("flslot_cleared", 64'(o_valid), 64'(0));

      // flush in the middle of a divide
      drive(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, MD_DIV, WB_MD, 1'b0, 1'b0, 100, 7, 0, 0);
      tick();
      valid = 1'b0;
      repeat (9) tick();
      flush = 1'b1;
      tick();
      flush = 1'b0;
      $display("flush div: valid=%0b ready=%0b", o_valid, o_ready);
      chk("fldiv_ready", 64'(o_ready), 64'(1));
      chk("fldiv_valid", 64'(o_valid), 64'(0));
      rises = 0;
      repeat (40) begin
         tick();
         if (o_valid) rises++;
      end
      chk("fldiv_no_result", 64'(rises), 64'(0));
      run_op("add_after_flush", ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, 2, 2, 0, 0, 4, 1'b0, 1'b0, 0);
      tick();

      // reset in the middle of a multiply
      drive(ALU_ADD, OPA_RS1, OPB_RS2, BR_NONE, MD_MUL, WB_MD, 1'b0, 1'b0, 9, 9, 0, 0);
      tick();
      valid = 1'b0;
      repeat (5) tick();
      rst = 1'b1;
      tick();
      chk("rstmul_valid", 64'(o_valid), 64'(0));
      chk("rstmul_ready", 64'(o_ready), 64'(0));
      rst = 1'b0;
      #1;
      $display("reset mid-mul: valid=%0b ready=%0b result=%h", o_valid, o_ready, o_result);
      chk("rstmul_ready_after", 64'(o_ready), 64'(1));
      chk("rstmul_result", 64'(o_result), 64'(0));
      rises = 0;
      repeat (40) begin
         tick();
         if (o_valid) rises++;
      end
      chk("rstmul_no_result", 64'(rises), 64'(0));
      run_md("mul_after_rst", MD_MUL, 1'b0, 1'b0, 6, 7, 42, 33);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
